serial_cmp6: RTL and testbench
==============================

SERIAL_CMP6 -- requirements
Module: serial_cmp6

Interface
REQ-001 Parameter EARLY_EXIT, default 1, meaning: 1 ends the scan at the first differing bit; 0 always scans all 6 bits.
REQ-002 clk  input  1  the single clock; every register updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous to clk and active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 sgn  input  1  compare mode, sampled with start: 0 = unsigned, 1 = two's-complement signed.
REQ-006 a0  input  6  operand A, sampled with start.
REQ-007 b0  input  6  operand B, sampled with start.
REQ-008 busy  output  1  high while in SCAN.
REQ-009 done  output  1  single-cycle pulse; high exactly while in DONE.
REQ-010 lt  output  1  result flag: A<B.
REQ-011 eq  output  1  result flag: A==B.
REQ-012 gt  output  1  result flag: A>B.

Function
REQ-013 The FSM shall have exactly three states, IDLE, SCAN and DONE, all registered.
REQ-014 IDLE with start=1 shall capture a0/b0/sgn, set idx=5, clear lt/eq/gt and go to SCAN on the next edge; IDLE with start=0 shall stay in IDLE.
REQ-015 SCAN shall compare the captured bits A[idx] and B[idx], one bit per cycle, MSB first.
REQ-016 Unsigned mode, differing bits: A[idx]=0 shall set lt and A[idx]=1 shall set gt.
REQ-017 Signed mode, differing bits at idx=5 only: the polarity shall be inverted, so A[5]=1 sets lt; bits 4..0 shall follow REQ-016.
REQ-018 EARLY_EXIT=1: the first differing bit shall set its flag and go to DONE on the same edge.
REQ-019 EARLY_EXIT=0: the first differing bit shall latch its flag; later bits shall not change it; the scan shall continue to idx=0.
REQ-020 At idx=0 with no difference found, eq shall be set and the FSM shall go to DONE; otherwise idx shall decrement.
REQ-021 DONE shall last exactly one cycle, then go to IDLE.
REQ-022 Latency, EARLY_EXIT=1, first difference at bit k: done shall be high in cycle 7-k after the start-sampling edge (cycle 1 = first SCAN cycle).
REQ-023 Latency, equal operands or EARLY_EXIT=0: done shall be high in cycle 7.
REQ-024 Exactly one of lt/eq/gt shall be high from DONE until the next accepted start; all three shall be 0 while busy.
REQ-025 start in SCAN or DONE shall be ignored with no effect; a start held high through DONE shall be accepted in the following IDLE cycle.
REQ-026 Operand or sgn changes after the accept edge shall not affect the result.
REQ-027 a0=b0 shall give eq=1 in both modes, including 6'h00 and 6'h3F.

Reset
REQ-028 rst=1 at any clock edge shall force IDLE, busy=0, done=0, lt=eq=gt=0 and idx=5, including mid-SCAN or in DONE.
REQ-029 A start sampled in the same cycle as rst=1 shall be discarded.
REQ-030 The first start shall be accepted in the first cycle with rst=0.

Structure
REQ-031 A shared package shall hold the constant CMP_W=6 and the enumerated state type {IDLE, SCAN, DONE}.
REQ-032 One sub-module, bit_cmp, shall be used: 1-bit combinational slice with inputs a, b, inv and outputs lt_bit, gt_bit.
REQ-033 serial_cmp6 shall instantiate bit_cmp once, driven by the bits at idx, with inv = sgn AND (idx==5).
REQ-034 All state shall be in serial_cmp6; bit_cmp shall contain no registers.

Verification
REQ-035 Unsigned, a0=6'h05, b0=6'h07, EARLY_EXIT=1 -> lt=1 with done in cycle 6 (k=1); busy high for cycles 1-5.
REQ-036 Signed, a0=6'h3F (-1), b0=6'h01 -> lt=1 with done in cycle 1+1=2; the same operands unsigned -> gt=1 with done in cycle 2.
REQ-037 a0=b0=6'h2A, both modes -> eq=1 with done in cycle 7; EARLY_EXIT=0 with a0=6'h20, b0=6'h00 -> gt=1 with done in cycle 7.
REQ-038 Start pulsed again in SCAN, and a0 changed mid-scan -> no restart and the result is unchanged.
REQ-039 rst asserted in SCAN cycle 3 -> next cycle IDLE with all outputs 0; a new start immediately after completes correctly.
REQ-040 Back-to-back: start held high continuously -> a new accept on the IDLE cycle after each DONE, with flags cleared at each accept.

Source files
------------

// File: rtl/serial_cmp6_pkg.sv
// Shared constants and state type for the serial 6-bit magnitude comparator.
package serial_cmp6_pkg;

    localparam int         CMP_W   = 6;
    localparam logic [2:0] IDX_MSB = 3'(CMP_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_cmp6_bit_cmp.sv
// One-bit compare slice; inv flips polarity for the sign bit of signed operands.
module bit_cmp (
    input  logic a,
    input  logic b,
    input  logic inv,
    output logic lt_bit,
    output logic gt_bit
);

    logic diff_s;

    assign diff_s = a ^ b;
    assign lt_bit = diff_s & (inv ? a : ~a);
    assign gt_bit = diff_s & (inv ? ~a : a);

endmodule

// File: rtl/serial_cmp6.sv
// Bit-serial 6-bit comparator, MSB first, unsigned or two's-complement signed.
module serial_cmp6
    import serial_cmp6_pkg::*;
#(
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic [CMP_W-1:0] a0,
    input  logic [CMP_W-1:0] b0,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    state_t           state_r, state_s;
    logic [2:0]       idx_r, idx_s;
    logic [CMP_W-1:0] a_r, a_s, b_r, b_s;
    logic             sgn_r, sgn_s;
    logic             hit_r, hit_s, hlt_r, hlt_s, hgt_r, hgt_s;
    logic             lt_r, lt_s, eq_r, eq_s, gt_r, gt_s;
    logic             busy_r, busy_s, done_r, done_s;
    logic             lt_bit_s, gt_bit_s, diff_s, inv_s;

    assign inv_s  = sgn_r & (idx_r == IDX_MSB);
    assign diff_s = lt_bit_s | gt_bit_s;

    bit_cmp u_bit_cmp (
        .a      (a_r[idx_r]),
        .b      (b_r[idx_r]),
        .inv    (inv_s),
        .lt_bit (lt_bit_s),
        .gt_bit (gt_bit_s)
    );

    // Next-state, datapath and registered-output values.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        a_s     = a_r;
        b_s     = b_r;
        sgn_s   = sgn_r;
        hit_s   = hit_r;
        hlt_s   = hlt_r;
        hgt_s   = hgt_r;
        lt_s    = lt_r;
        eq_s    = eq_r;
        gt_s    = gt_r;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = SCAN;
                    a_s     = a0;
                    b_s     = b0;
                    sgn_s   = sgn;
                    idx_s   = IDX_MSB;
                    hit_s   = 1'b0;
                    hlt_s   = 1'b0;
                    hgt_s   = 1'b0;
                    lt_s    = 1'b0;
                    eq_s    = 1'b0;
                    gt_s    = 1'b0;
                    busy_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                if ((EARLY_EXIT != 0) && diff_s) begin
                    state_s = DONE;
                    lt_s    = lt_bit_s;
                    gt_s    = gt_bit_s;
                    done_s  = 1'b1;
                end else if (idx_r == 3'd0) begin
                    state_s = DONE;
                    done_s  = 1'b1;
                    // Without early exit the first difference seen wins.
                    if (hit_r) begin
                        lt_s = hlt_r;
                        gt_s = hgt_r;
                    end else if (diff_s) begin
                        lt_s = lt_bit_s;
                        gt_s = gt_bit_s;
                    end else begin
                        eq_s = 1'b1;
                    end
                end else begin
                    idx_s  = idx_r - 3'd1;
                    busy_s = 1'b1;
                    if (diff_s && !hit_r) begin
                        hit_s = 1'b1;
                        hlt_s = lt_bit_s;
                        hgt_s = gt_bit_s;
                    end else begin
                        hit_s = hit_r;
                    end
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= IDX_MSB;
            a_r     <= '0;
            b_r     <= '0;
            sgn_r   <= 1'b0;
            hit_r   <= 1'b0;
            hlt_r   <= 1'b0;
            hgt_r   <= 1'b0;
            lt_r    <= 1'b0;
            eq_r    <= 1'b0;
            gt_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            a_r     <= a_s;
            b_r     <= b_s;
            sgn_r   <= sgn_s;
            hit_r   <= hit_s;
            hlt_r   <= hlt_s;
            hgt_r   <= hgt_s;
            lt_r    <= lt_s;
            eq_r    <= eq_s;
            gt_r    <= gt_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign lt   = lt_r;
    assign eq   = eq_r;
    assign gt   = gt_r;

endmodule

// File: tb/tb_serial_cmp6.sv
// Scoreboard bench: two comparators (early exit on/off) share stimulus; a per-instance monitor checks timing and flags.
module tb_serial_cmp6;

    typedef struct {
        int         acc;
        int         dn;
        logic [2:0] f;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       sgn = 1'b0;
    logic [5:0] a0 = 6'h00;
    logic [5:0] b0 = 6'h00;
    logic       busy1, done1, lt1, eq1, gt1;
    logic       busy0, done0, lt0, eq0, gt0;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q1[$];
    exp_t q0[$];
    logic [2:0] last1 = 3'b000;
    logic [2:0] last0 = 3'b000;

    serial_cmp6 #(.EARLY_EXIT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .sgn(sgn), .a0(a0), .b0(b0),
        .busy(busy1), .done(done1), .lt(lt1), .eq(eq1), .gt(gt1)
    );

    serial_cmp6 #(.EARLY_EXIT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .sgn(sgn), .a0(a0), .b0(b0),
        .busy(busy0), .done(done0), .lt(lt0), .eq(eq0), .gt(gt0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: compare as integers; flags are {lt, eq, gt}.
    function automatic logic [2:0] ref_flags(input logic [5:0] a, input logic [5:0] b, input logic s);
        int ia, ib;
        if (s) begin
            ia = int'($signed(a));
            ib = int'($signed(b));
        end else begin
            ia = int'(a);
            ib = int'(b);
        end
        if (ia < ib) return 3'b100;
        else if (ia == ib) return 3'b010;
        else return 3'b001;
    endfunction

    // Reference latency: cycle (counted from first scan cycle) in which done is high.
    function automatic int ref_lat(input logic [5:0] a, input logic [5:0] b, input int ee);
        int k;
        k = -1;
        for (int i = 0; i < 6; i++) if (a[i] != b[i]) k = i;
        if (ee != 0 && k >= 0) return 7 - k;
        else return 7;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    task automatic mon(input int d, input logic bz, input logic dn, input logic [2:0] f);
        exp_t e;
        int   n;
        logic [2:0] last;
        n    = (d == 1) ? q1.size() : q0.size();
        last = (d == 1) ? last1 : last0;
        if (n > 0) begin
            e = (d == 1) ? q1[0] : q0[0];
            if (dn || cyc >= e.dn) begin
                check($sformatf("dut%0d done_cycle", d), cyc, e.dn);
                check($sformatf("dut%0d done", d), int'(dn), 1);
                check($sformatf("dut%0d flags", d), int'(f), int'(e.f));
                if (d == 1) begin
                    void'(q1.pop_front());
                    last1 = e.f;
                end else begin
                    void'(q0.pop_front());
                    last0 = e.f;
                end
            end else if (cyc >= e.acc) begin
                check($sformatf("dut%0d busy_scan", d), int'(bz), 1);
                check($sformatf("dut%0d flags_busy", d), int'(f), 0);
            end else begin
                check($sformatf("dut%0d busy_idle", d), int'(bz), 0);
                check($sformatf("dut%0d flags_idle", d), int'(f), int'(last));
            end
        end else begin
            check($sformatf("dut%0d busy_idle", d), int'(bz), 0);
            check($sformatf("dut%0d done_idle", d), int'(dn), 0);
            check($sformatf("dut%0d flags_idle", d), int'(f), int'(last));
        end
    endtask

    // Monitor: compares both instances against the scoreboard every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            mon(1, busy1, done1, {lt1, eq1, gt1});
            mon(0, busy0, done0, {lt0, eq0, gt0});
        end
    end

    task automatic push(input logic [5:0] a, input logic [5:0] b, input logic s, input int acc);
        exp_t e;
        e.acc = acc;
        e.f   = ref_flags(a, b, s);
        e.dn  = acc + ref_lat(a, b, 1) - 1;
        q1.push_back(e);
        e.dn  = acc + ref_lat(a, b, 0) - 1;
        q0.push_back(e);
    endtask

    // Issue one compare at a negedge; optionally disturb start/operands while both are busy.
    task automatic run(input logic [5:0] a, input logic [5:0] b, input logic s, input bit junk);
        int acc, l1, rel;
        a0 = a; b0 = b; sgn = s; start = 1'b1;
        acc = cyc + 1;
        l1  = ref_lat(a, b, 1);
        push(a, b, s, acc);
        @(negedge clk);
        while (cyc <= acc + 6) begin
            rel = cyc - acc + 1;
            if (junk && rel <= l1) begin
                start = 1'($urandom);
                a0 = 6'($urandom); b0 = 6'($urandom); sgn = 1'($urandom);
            end else begin
                start = 1'b0;
                a0 = 6'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        int acc0, acc;
        logic [5:0] a, b;
        logic       s;
        fork
            begin
                #2000000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset with start asserted: the start must be discarded.
        start = 1'b1; a0 = 6'h11; b0 = 6'h22;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        run(6'h05, 6'h07, 1'b0, 1'b0);
        run(6'h3F, 6'h01, 1'b1, 1'b0);
        run(6'h3F, 6'h01, 1'b0, 1'b0);
        run(6'h2A, 6'h2A, 1'b0, 1'b0);
        run(6'h2A, 6'h2A, 1'b1, 1'b0);
        run(6'h20, 6'h00, 1'b0, 1'b0);
        run(6'h00, 6'h00, 1'b1, 1'b0);
        run(6'h3F, 6'h3F, 1'b0, 1'b0);
        run(6'h20, 6'h1F, 1'b1, 1'b1);
        run(6'h10, 6'h11, 1'b0, 1'b1);

        // Reset during scan cycle 3 with start high, then an immediate new compare.
        a0 = 6'h2A; b0 = 6'h2B; sgn = 1'b0; start = 1'b1;
        acc = cyc + 1;
        push(6'h2A, 6'h2B, 1'b0, acc);
        @(negedge clk);
        start = 1'b0;
        while (cyc < acc + 2) @(negedge clk);
        rst = 1'b1; start = 1'b1; a0 = 6'h01; b0 = 6'h3E;
        @(posedge clk);
        q1.delete(); q0.delete();
        last1 = 3'b000; last0 = 3'b000;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        run(6'h01, 6'h3E, 1'b1, 1'b0);

        // Random compares, some with disturbances during the scan.
        for (int i = 0; i < 150; i++) begin
            a = 6'($urandom); b = 6'($urandom); s = 1'($urandom);
            if (i % 7 == 0) b = a;
            run(a, b, s, bit'($urandom_range(1, 0)));
        end

        // Back-to-back: start held high; each instance re-accepts after every DONE.
        for (int r = 0; r < 3; r++) begin
            exp_t e;
            int   l;
            a = 6'($urandom); b = 6'($urandom); s = 1'($urandom);
            if (r == 0) b = a ^ 6'h04;
            a0 = a; b0 = b; sgn = s; start = 1'b1;
            acc0 = cyc + 1;
            e.f = ref_flags(a, b, s);
            l = ref_lat(a, b, 1);
            for (acc = acc0; acc <= acc0 + 29; acc += l + 1) begin
                e.acc = acc; e.dn = acc + l - 1; q1.push_back(e);
            end
            l = ref_lat(a, b, 0);
            for (acc = acc0; acc <= acc0 + 29; acc += l + 1) begin
                e.acc = acc; e.dn = acc + l - 1; q0.push_back(e);
            end
            repeat (30) @(negedge clk);
            start = 1'b0;
            repeat (10) @(negedge clk);
        end

        check("q1_drained", q1.size(), 0);
        check("q0_drained", q0.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
